// File: rtl/itlb_l2_tlb_req_ctrl_pkg.sv
// Shared types for the ITLB -> L2 TLB miss-request path: geometry, Sv32 PTE layout
// and the per-tag request entry.
package itlb_l2_tlb_req_ctrl_pkg;

    localparam int unsigned ITLB_L2_TLB_REQ_TAG_COUNT = 4;
    localparam int unsigned ITLB_L2_TLB_REQ_TAG_WIDTH = 2;
    localparam int unsigned VPN_WIDTH                 = 20;
    localparam int unsigned ASID_WIDTH                = 16;

    typedef struct packed {
        logic [21:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef enum logic [1:0] {
        FREE,
        PENDING,
        SENT,
        SQUASHED
    } itlb_req_state_t;

    typedef struct packed {
        itlb_req_state_t        state;
        logic [VPN_WIDTH-1:0]   VPN;
        logic [ASID_WIDTH-1:0]  ASID;
    } itlb_req_entry_t;

endpackage

// File: rtl/itlb_l2_tlb_req_ctrl_pe_lsb.sv
// Lowest-index priority encoder: reports whether any request bit is set and the
// index of the least significant one.
module itlb_l2_tlb_req_ctrl_pe_lsb #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [WIDTH-1:0] i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        // Walk downward so the last hit written is the lowest index.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/itlb_l2_tlb_req_ctrl.sv
// ITLB miss-request controller: merges duplicate misses, tracks one tagged request per
// unique miss towards the L2 TLB and turns tagged responses into a registered ITLB fill.
module itlb_l2_tlb_req_ctrl
    import itlb_l2_tlb_req_ctrl_pkg::*;
(
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic                                 miss_valid,
    input  logic [VPN_WIDTH-1:0]                 miss_VPN,
    input  logic [ASID_WIDTH-1:0]                miss_ASID,
    output logic                                 miss_ready,
    output logic                                 req_valid,
    output logic [ITLB_L2_TLB_REQ_TAG_WIDTH-1:0] req_tag,
    output logic [VPN_WIDTH-1:0]                 req_VPN,
    output logic [ASID_WIDTH-1:0]                req_ASID,
    input  logic                                 req_ready,
    input  logic                                 resp_valid,
    input  logic [ITLB_L2_TLB_REQ_TAG_WIDTH-1:0] resp_tag,
    input  pte_t                                 resp_pte,
    input  logic                                 resp_is_4MB,
    input  logic                                 resp_page_fault,
    output logic                                 fill_valid,
    output logic [VPN_WIDTH-1:0]                 fill_VPN,
    output logic [ASID_WIDTH-1:0]                fill_ASID,
    output pte_t                                 fill_pte,
    output logic                                 fill_is_4MB,
    output logic                                 fill_page_fault,
    input  logic                                 flush
);

    localparam int unsigned N  = ITLB_L2_TLB_REQ_TAG_COUNT;
    localparam int unsigned TW = ITLB_L2_TLB_REQ_TAG_WIDTH;

    itlb_req_entry_t r_entries [N];
    itlb_req_entry_t w_entries_d [N];

    logic                  r_hold;
    logic [TW-1:0]         r_hold_idx;
    logic                  r_fill_valid;
    logic [VPN_WIDTH-1:0]  r_fill_vpn;
    logic [ASID_WIDTH-1:0] r_fill_asid;
    pte_t                  r_fill_pte;
    logic                  r_fill_is_4mb;
    logic                  r_fill_page_fault;

    logic [N-1:0]  w_free;
    logic [N-1:0]  w_pend;
    logic [N-1:0]  w_match;
    logic [N-1:0]  w_resp_hit;
    logic          w_any_free;
    logic          w_any_pend;
    logic [TW-1:0] w_free_idx;
    logic [TW-1:0] w_pend_idx;
    logic [TW-1:0] w_req_idx;
    logic          w_merge;
    logic          w_accept;
    logic          w_alloc;
    logic          w_req_valid;
    logic          w_hs;
    logic          w_fill;
    logic          w_resp_live;

    // Per-entry status vectors; an entry taking a response this cycle cannot absorb a merge.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_free[i]     = (r_entries[i].state == FREE);
            w_pend[i]     = (r_entries[i].state == PENDING);
            w_resp_hit[i] = resp_valid && (resp_tag == TW'(i)) &&
                            ((r_entries[i].state == SENT) || (r_entries[i].state == SQUASHED));
            w_match[i]    = ((r_entries[i].state == PENDING) || (r_entries[i].state == SENT)) &&
                            (r_entries[i].VPN == miss_VPN) && (r_entries[i].ASID == miss_ASID) &&
                            !w_resp_hit[i];
        end
    end

    itlb_l2_tlb_req_ctrl_pe_lsb #(
        .WIDTH (N),
        .IDX_W (TW)
    ) u_pe_free (
        .i_req   (w_free),
        .o_valid (w_any_free),
        .o_idx   (w_free_idx)
    );

    itlb_l2_tlb_req_ctrl_pe_lsb #(
        .WIDTH (N),
        .IDX_W (TW)
    ) u_pe_pend (
        .i_req   (w_pend),
        .o_valid (w_any_pend),
        .o_idx   (w_pend_idx)
    );

    assign w_merge  = |w_match;
    assign w_accept = nRST && miss_valid && !flush && (w_merge || w_any_free);
    assign w_alloc  = w_accept && !w_merge;

    // A stalled request keeps its tag even if a lower-index entry becomes PENDING meanwhile.
    assign w_req_idx   = r_hold ? r_hold_idx : w_pend_idx;
    assign w_req_valid = nRST && w_any_pend;
    assign w_hs        = w_req_valid && req_ready;

    assign w_fill      = resp_valid && (r_entries[resp_tag].state == SENT) && !flush;
    assign w_resp_live = (r_entries[resp_tag].state == SENT) ||
                         (r_entries[resp_tag].state == SQUASHED);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_entries_d[i] = r_entries[i];
            unique case (r_entries[i].state)
                FREE: begin
                    if (w_alloc && (w_free_idx == TW'(i))) begin
                        w_entries_d[i].state = PENDING;
                        w_entries_d[i].VPN   = miss_VPN;
                        w_entries_d[i].ASID  = miss_ASID;
                    end
                end
                PENDING: begin
                    // A request that handshakes under flush is still answered by the L2 TLB.
                    if (w_hs && (w_req_idx == TW'(i))) begin
                        w_entries_d[i].state = flush ? SQUASHED : SENT;
                    end else if (flush) begin
                        w_entries_d[i].state = FREE;
                    end
                end
                SENT: begin
                    if (w_resp_hit[i]) begin
                        w_entries_d[i].state = FREE;
                    end else if (flush) begin
                        w_entries_d[i].state = SQUASHED;
                    end
                end
                SQUASHED: begin
                    if (w_resp_hit[i]) begin
                        w_entries_d[i].state = FREE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < N; i++) begin
                r_entries[i] <= '{state: FREE, VPN: '0, ASID: '0};
            end
            r_hold            <= 1'b0;
            r_hold_idx        <= '0;
            r_fill_valid      <= 1'b0;
            r_fill_vpn        <= '0;
            r_fill_asid       <= '0;
            r_fill_pte        <= '0;
            r_fill_is_4mb     <= 1'b0;
            r_fill_page_fault <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_entries[i] <= w_entries_d[i];
            end
            r_hold       <= w_req_valid && !req_ready && !flush;
            r_hold_idx   <= w_req_idx;
            r_fill_valid <= w_fill;
            if (w_fill) begin
                r_fill_vpn        <= r_entries[resp_tag].VPN;
                r_fill_asid       <= r_entries[resp_tag].ASID;
                r_fill_pte        <= resp_pte;
                r_fill_is_4mb     <= resp_is_4MB;
                r_fill_page_fault <= resp_page_fault;
            end
        end
    end

    assign miss_ready      = w_accept;
    assign req_valid       = w_req_valid;
    assign req_tag         = w_req_valid ? w_req_idx : '0;
    assign req_VPN         = w_req_valid ? r_entries[w_req_idx].VPN : '0;
    assign req_ASID        = w_req_valid ? r_entries[w_req_idx].ASID : '0;
    assign fill_valid      = r_fill_valid;
    assign fill_VPN        = r_fill_vpn;
    assign fill_ASID       = r_fill_asid;
    assign fill_pte        = r_fill_pte;
    assign fill_is_4MB     = r_fill_is_4mb;
    assign fill_page_fault = r_fill_page_fault;

    // Responses may only name tags that actually have a request outstanding.
    a_resp_to_live_tag: assert property (@(posedge CLK) disable iff (!nRST)
        resp_valid |-> w_resp_live);

endmodule

// File: tb/tb_itlb_l2_tlb_req_ctrl.sv
// Randomized and directed bench for itlb_l2_tlb_req_ctrl against a flag-based tag model.
module tb_itlb_l2_tlb_req_ctrl;

    localparam int N = 4;

    logic        CLK;
    logic        nRST;
    logic        miss_valid;
    logic [19:0] miss_VPN;
    logic [15:0] miss_ASID;
    logic        miss_ready;
    logic        req_valid;
    logic [1:0]  req_tag;
    logic [19:0] req_VPN;
    logic [15:0] req_ASID;
    logic        req_ready;
    logic        resp_valid;
    logic [1:0]  resp_tag;
    logic [31:0] resp_pte;
    logic        resp_is_4MB;
    logic        resp_page_fault;
    logic        fill_valid;
    logic [19:0] fill_VPN;
    logic [15:0] fill_ASID;
    logic [31:0] fill_pte;
    logic        fill_is_4MB;
    logic        fill_page_fault;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    itlb_l2_tlb_req_ctrl dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .miss_valid      (miss_valid),
        .miss_VPN        (miss_VPN),
        .miss_ASID       (miss_ASID),
        .miss_ready      (miss_ready),
        .req_valid       (req_valid),
        .req_tag         (req_tag),
        .req_VPN         (req_VPN),
        .req_ASID        (req_ASID),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_tag        (resp_tag),
        .resp_pte        (resp_pte),
        .resp_is_4MB     (resp_is_4MB),
        .resp_page_fault (resp_page_fault),
        .fill_valid      (fill_valid),
        .fill_VPN        (fill_VPN),
        .fill_ASID       (fill_ASID),
        .fill_pte        (fill_pte),
        .fill_is_4MB     (fill_is_4MB),
        .fill_page_fault (fill_page_fault),
        .flush           (flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: per-tag flags (allocated / request sent / squashed by flush).
    logic        m_busy [N];
    logic        m_sent [N];
    logic        m_dead [N];
    logic [19:0] m_vpn  [N];
    logic [15:0] m_asid [N];
    logic        m_lock;
    int          m_lock_tag;
    logic        e_merge;
    int          e_free;
    logic        exp_miss_ready;
    logic        exp_req_valid;
    logic [1:0]  exp_req_tag;
    logic [19:0] exp_req_vpn;
    logic [15:0] exp_req_asid;
    logic        exp_fill_valid = 1'b0;
    logic [19:0] exp_fill_vpn   = '0;
    logic [15:0] exp_fill_asid  = '0;
    logic [31:0] exp_fill_pte   = '0;
    logic        exp_fill_4mb   = 1'b0;
    logic        exp_fill_pf    = 1'b0;

    task automatic model_eval();
        int pend;
        pend    = -1;
        e_merge = 1'b0;
        e_free  = -1;
        for (int t = 0; t < N; t++) begin
            if (m_busy[t] && !m_dead[t] && m_vpn[t] == miss_VPN && m_asid[t] == miss_ASID &&
                !(resp_valid && int'(resp_tag) == t && m_sent[t]))
                e_merge = 1'b1;
            if (!m_busy[t] && e_free < 0) e_free = t;
            if (m_busy[t] && !m_sent[t] && pend < 0) pend = t;
        end
        exp_miss_ready = nRST && miss_valid && !flush && (e_merge || e_free >= 0);
        if (m_lock) pend = m_lock_tag;
        exp_req_valid = nRST && (pend >= 0);
        exp_req_tag   = exp_req_valid ? 2'(pend) : 2'd0;
        exp_req_vpn   = exp_req_valid ? m_vpn[pend] : 20'd0;
        exp_req_asid  = exp_req_valid ? m_asid[pend] : 16'd0;
    endtask

    task automatic model_commit();
        logic hs;
        logic rh;
        logic fl;
        int   ht;
        int   rt;
        if (!nRST) begin
            for (int t = 0; t < N; t++) begin
                m_busy[t] = 1'b0;
                m_sent[t] = 1'b0;
                m_dead[t] = 1'b0;
                m_vpn[t]  = '0;
                m_asid[t] = '0;
            end
            m_lock         = 1'b0;
            m_lock_tag     = 0;
            exp_fill_valid = 1'b0;
            exp_fill_vpn   = '0;
            exp_fill_asid  = '0;
            exp_fill_pte   = '0;
            exp_fill_4mb   = 1'b0;
            exp_fill_pf    = 1'b0;
            return;
        end
        hs = exp_req_valid && req_ready;
        ht = int'(exp_req_tag);
        rt = int'(resp_tag);
        rh = resp_valid && m_busy[rt] && m_sent[rt];
        fl = rh && !m_dead[rt] && !flush;
        exp_fill_valid = fl;
        if (fl) begin
            exp_fill_vpn  = m_vpn[rt];
            exp_fill_asid = m_asid[rt];
            exp_fill_pte  = resp_pte;
            exp_fill_4mb  = resp_is_4MB;
            exp_fill_pf   = resp_page_fault;
        end
        if (flush) begin
            for (int t = 0; t < N; t++) begin
                if (m_busy[t] && !m_sent[t] && !(hs && t == ht)) m_busy[t] = 1'b0;
                else if (m_busy[t] && m_sent[t]) m_dead[t] = 1'b1;
            end
        end
        if (hs) begin
            m_sent[ht] = 1'b1;
            if (flush) m_dead[ht] = 1'b1;
        end
        if (rh) begin
            m_busy[rt] = 1'b0;
            m_sent[rt] = 1'b0;
            m_dead[rt] = 1'b0;
        end
        if (exp_miss_ready && !e_merge) begin
            m_busy[e_free] = 1'b1;
            m_sent[e_free] = 1'b0;
            m_dead[e_free] = 1'b0;
            m_vpn[e_free]  = miss_VPN;
            m_asid[e_free] = miss_ASID;
        end
        m_lock     = exp_req_valid && !req_ready && !flush;
        m_lock_tag = ht;
    endtask

    task automatic advance();
        model_eval();
        @(posedge CLK);
        model_commit();
        @(negedge CLK);
    endtask

    task automatic idle();
        miss_valid      = 1'b0;
        miss_VPN        = '0;
        miss_ASID       = '0;
        resp_valid      = 1'b0;
        resp_tag        = '0;
        resp_pte        = '0;
        resp_is_4MB     = 1'b0;
        resp_page_fault = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic miss(input logic [19:0] vpn, input logic [15:0] asid);
        miss_valid = 1'b1;
        miss_VPN   = vpn;
        miss_ASID  = asid;
    endtask

    task automatic do_reset();
        idle();
        req_ready = 1'b0;
        nRST      = 1'b0;
        advance();
        advance();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        req_ready = 1'b1;
        nRST      = 1'b0;
        advance();
        miss(20'h00AAA, 16'h0001);
        #1;
        checks++; if (miss_ready !== 1'b0) begin failures++; $display("FAIL reset_miss_ready got=%0b want=0", miss_ready); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b want=0", req_valid); end
        checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL reset_fill_valid got=%0b want=0", fill_valid); end
        checks++; if ({req_tag, req_VPN, req_ASID, fill_VPN, fill_ASID, fill_pte, fill_is_4MB, fill_page_fault} !== '0) begin
            failures++; $display("FAIL reset_data got req=%h/%h fill=%h/%h/%h want all zero", req_VPN, req_ASID, fill_VPN, fill_ASID, fill_pte);
        end
        advance();
        nRST = 1'b1;
        idle();
    endtask

    task automatic test_basic();
        do_reset();
        req_ready = 1'b1;
        miss(20'h12345, 16'h0001);
        #1;
        checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL basic_miss_ready got=%0b want=1", miss_ready); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL basic_no_bypass got=%0b want=0", req_valid); end
        advance();
        idle();
        #1;
        checks++; if ({req_valid, req_tag, req_VPN, req_ASID} !== {1'b1, 2'd0, 20'h12345, 16'h0001}) begin
            failures++; $display("FAIL basic_req got=%0b/%0d/%h/%h want=1/0/12345/0001", req_valid, req_tag, req_VPN, req_ASID);
        end
        advance();
        resp_valid = 1'b1;
        resp_tag   = 2'd0;
        resp_pte   = 32'h0ABCD0CF;
        #1;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL basic_req_done got=%0b want=0", req_valid); end
        checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL basic_fill_early got=%0b want=0", fill_valid); end
        advance();
        idle();
        #1;
        checks++; if ({fill_valid, fill_VPN, fill_ASID, fill_pte, fill_is_4MB, fill_page_fault} !==
                      {1'b1, 20'h12345, 16'h0001, 32'h0ABCD0CF, 1'b0, 1'b0}) begin
            failures++; $display("FAIL basic_fill got=%0b/%h/%h/%h/%0b/%0b want=1/12345/0001/0abcd0cf/0/0",
                                 fill_valid, fill_VPN, fill_ASID, fill_pte, fill_is_4MB, fill_page_fault);
        end
        advance();
        #1;
        checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL basic_fill_one_cycle got=%0b want=0", fill_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        req_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            miss(20'(v), 16'h0001);
            #1;
            checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL stall_fill_table v=%0d got=%0b want=1", v, miss_ready); end
            advance();
        end
        miss(20'h5, 16'h0001);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (miss_ready !== 1'b0) begin failures++; $display("FAIL stall_full c=%0d got=%0b want=0", c, miss_ready); end
            advance();
        end
        resp_valid = 1'b1;
        resp_tag   = 2'd2;
        resp_pte   = 32'h00001001;
        #1;
        checks++; if (miss_ready !== 1'b0) begin failures++; $display("FAIL stall_freed_same_cycle got=%0b want=0", miss_ready); end
        advance();
        resp_valid = 1'b0;
        #1;
        checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%0b want=1", miss_ready); end
        checks++; if ({fill_valid, fill_VPN} !== {1'b1, 20'h3}) begin
            failures++; $display("FAIL stall_fill got=%0b/%h want=1/00003", fill_valid, fill_VPN);
        end
        advance();
        idle();
        #1;
        checks++; if ({req_valid, req_tag, req_VPN} !== {1'b1, 2'd2, 20'h5}) begin
            failures++; $display("FAIL stall_reuse_tag got=%0b/%0d/%h want=1/2/00005", req_valid, req_tag, req_VPN);
        end
        advance();
    endtask

    task automatic test_merge();
        do_reset();
        req_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            miss(20'(v), 16'h0001);
            advance();
        end
        idle();
        advance();
        miss(20'h3, 16'h0001);
        #1;
        checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL merge_full_ready got=%0b want=1", miss_ready); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL merge_no_req got=%0b want=0", req_valid); end
        advance();
        miss(20'h3, 16'h0002);
        #1;
        checks++; if (miss_ready !== 1'b0) begin failures++; $display("FAIL merge_asid_differs got=%0b want=0", miss_ready); end
        advance();
        miss(20'h3, 16'h0001);
        resp_valid = 1'b1;
        resp_tag   = 2'd2;
        resp_pte   = 32'h12345C01;
        #1;
        checks++; if (miss_ready !== 1'b0) begin failures++; $display("FAIL merge_resp_excluded got=%0b want=0", miss_ready); end
        advance();
        idle();
        #1;
        checks++; if ({fill_valid, fill_VPN, fill_pte} !== {1'b1, 20'h3, 32'h12345C01}) begin
            failures++; $display("FAIL merge_fill got=%0b/%h/%h want=1/00003/12345c01", fill_valid, fill_VPN, fill_pte);
        end
        advance();
        #1;
        checks++; if ({fill_valid, req_valid} !== 2'b00) begin
            failures++; $display("FAIL merge_single_fill got=%0b/%0b want=0/0", fill_valid, req_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        req_ready = 1'b1;
        miss(20'hA0, 16'h0007);
        advance();
        miss(20'hA1, 16'h0007);
        advance();
        miss(20'hA2, 16'h0007);
        advance();
        req_ready = 1'b0;
        miss(20'hA3, 16'h0007);
        flush = 1'b1;
        #1;
        checks++; if ({req_valid, req_tag} !== {1'b1, 2'd2}) begin
            failures++; $display("FAIL flush_pending_tag got=%0b/%0d want=1/2", req_valid, req_tag);
        end
        checks++; if (miss_ready !== 1'b0) begin failures++; $display("FAIL flush_blocks_miss got=%0b want=0", miss_ready); end
        advance();
        idle();
        req_ready = 1'b1;
        resp_valid = 1'b1;
        resp_tag   = 2'd0;
        #1;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL flush_pending_dropped got=%0b want=0", req_valid); end
        advance();
        resp_tag = 2'd1;
        #1;
        checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL flush_squash_fill0 got=%0b want=0", fill_valid); end
        advance();
        idle();
        req_ready = 1'b0;
        #1;
        checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL flush_squash_fill1 got=%0b want=0", fill_valid); end
        for (int v = 0; v < 4; v++) begin
            miss(20'hB0 + 20'(v), 16'h0007);
            #1;
            checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL flush_realloc v=%0d got=%0b want=1", v, miss_ready); end
            advance();
        end
        miss(20'hBF, 16'h0007);
        #1;
        checks++; if (miss_ready !== 1'b0) begin failures++; $display("FAIL flush_refull got=%0b want=0", miss_ready); end
        advance();
        idle();
    endtask

    task automatic test_hold();
        do_reset();
        req_ready = 1'b0;
        miss(20'h00100, 16'h0003);
        advance();
        miss(20'h00200, 16'h0003);
        advance();
        idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({req_valid, req_tag, req_VPN} !== {1'b1, 2'd0, 20'h00100}) begin
                failures++; $display("FAIL hold_stable c=%0d got=%0b/%0d/%h want=1/0/00100", c, req_valid, req_tag, req_VPN);
            end
            advance();
        end
        req_ready = 1'b1;
        #1;
        checks++; if ({req_valid, req_tag} !== {1'b1, 2'd0}) begin
            failures++; $display("FAIL hold_first_hs got=%0b/%0d want=1/0", req_valid, req_tag);
        end
        advance();
        #1;
        checks++; if ({req_valid, req_tag, req_VPN} !== {1'b1, 2'd1, 20'h00200}) begin
            failures++; $display("FAIL hold_second_hs got=%0b/%0d/%h want=1/1/00200", req_valid, req_tag, req_VPN);
        end
        advance();
        #1;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL hold_drained got=%0b want=0", req_valid); end
    endtask

    task automatic test_fault();
        logic [31:0] pte;
        pte = $urandom;
        do_reset();
        req_ready = 1'b1;
        miss(20'h10, 16'h0004);
        advance();
        miss(20'h11, 16'h0004);
        advance();
        idle();
        advance();
        resp_valid      = 1'b1;
        resp_tag        = 2'd1;
        resp_pte        = pte;
        resp_is_4MB     = 1'b1;
        resp_page_fault = 1'b1;
        advance();
        idle();
        miss(20'h22, 16'h0004);
        #1;
        checks++; if ({fill_valid, fill_VPN, fill_pte, fill_is_4MB, fill_page_fault} !== {1'b1, 20'h11, pte, 1'b1, 1'b1}) begin
            failures++; $display("FAIL fault_fill got=%0b/%h/%h/%0b/%0b want=1/00011/%h/1/1",
                                 fill_valid, fill_VPN, fill_pte, fill_is_4MB, fill_page_fault, pte);
        end
        checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL fault_reuse_ready got=%0b want=1", miss_ready); end
        advance();
        idle();
        #1;
        checks++; if ({req_valid, req_tag, req_VPN} !== {1'b1, 2'd1, 20'h22}) begin
            failures++; $display("FAIL fault_reuse_tag got=%0b/%0d/%h want=1/1/00022", req_valid, req_tag, req_VPN);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            miss(20'h40 + 20'(v), 16'h0009);
            advance();
        end
        nRST = 1'b0;
        miss(20'h40, 16'h0009);
        #1;
        checks++; if ({miss_ready, req_valid} !== 2'b00) begin
            failures++; $display("FAIL midreset_outputs got=%0b/%0b want=0/0", miss_ready, req_valid);
        end
        advance();
        nRST = 1'b1;
        idle();
        #1;
        checks++; if ({req_valid, fill_valid} !== 2'b00) begin
            failures++; $display("FAIL midreset_cleared got=%0b/%0b want=0/0", req_valid, fill_valid);
        end
        miss(20'h40, 16'h0009);
        advance();
        idle();
        #1;
        checks++; if ({req_valid, req_tag, req_VPN} !== {1'b1, 2'd0, 20'h40}) begin
            failures++; $display("FAIL midreset_realloc got=%0b/%0d/%h want=1/0/00040", req_valid, req_tag, req_VPN);
        end
        advance();
    endtask

    task automatic test_random();
        int cand [$];
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            miss_valid = ($urandom_range(0, 9) < 6);
            miss_VPN   = 20'($urandom_range(0, 7));
            miss_ASID  = 16'($urandom_range(0, 1));
            req_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 99) < 3);
            cand.delete();
            for (int t = 0; t < N; t++) if (m_busy[t] && m_sent[t]) cand.push_back(t);
            if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
                resp_valid      = 1'b1;
                resp_tag        = 2'(cand[$urandom_range(0, cand.size() - 1)]);
                resp_pte        = $urandom;
                resp_is_4MB     = 1'($urandom);
                resp_page_fault = 1'($urandom);
            end
            #1;
            model_eval();
            checks++; if (miss_ready !== exp_miss_ready) begin
                failures++; $display("FAIL rand_miss_ready c=%0d got=%0b want=%0b", c, miss_ready, exp_miss_ready);
            end
            checks++; if ({req_valid, req_tag, req_VPN, req_ASID} !== {exp_req_valid, exp_req_tag, exp_req_vpn, exp_req_asid}) begin
                failures++; $display("FAIL rand_req c=%0d got=%0b/%0d/%h/%h want=%0b/%0d/%h/%h", c, req_valid, req_tag,
                                     req_VPN, req_ASID, exp_req_valid, exp_req_tag, exp_req_vpn, exp_req_asid);
            end
            checks++; if ({fill_valid, fill_VPN, fill_ASID, fill_pte, fill_is_4MB, fill_page_fault} !==
                          {exp_fill_valid, exp_fill_vpn, exp_fill_asid, exp_fill_pte, exp_fill_4mb, exp_fill_pf}) begin
                failures++; $display("FAIL rand_fill c=%0d got=%0b/%h/%h/%h/%0b/%0b want=%0b/%h/%h/%h/%0b/%0b", c,
                                     fill_valid, fill_VPN, fill_ASID, fill_pte, fill_is_4MB, fill_page_fault,
                                     exp_fill_valid, exp_fill_vpn, exp_fill_asid, exp_fill_pte, exp_fill_4mb, exp_fill_pf);
            end
            advance();
        end
        idle();
    endtask

    initial begin
        idle();
        req_ready = 1'b0;
        nRST      = 1'b0;
        @(negedge CLK);
        test_reset();
        test_basic();
        test_stall();
        test_merge();
        test_flush();
        test_hold();
        test_fault();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/itlb_l2_tlb_req_ctrl.md
Name: itlb_l2_tlb_req_ctrl

Overview:
Miss-request controller between the ITLB (4KB and 4MB page arrays) and the L2 TLB. It accepts ITLB misses and merges duplicate misses. It allocates one of ITLB_L2_TLB_REQ_TAG_COUNT request tags per unique miss, issues requests to the L2 TLB, and matches tagged responses back to entries. It then produces a registered fill toward the ITLB arrays, and handles flush with in-flight requests.

Parameters:
TAG_COUNT, ITLB_L2_TLB_REQ_TAG_COUNT (4), number of outstanding request tags
TAG_WIDTH, ITLB_L2_TLB_REQ_TAG_WIDTH (2), tag width
VPN_W, VPN_WIDTH (20), virtual page number width
ASID_W, ASID_WIDTH (16), address space ID width

Ports:
CLK  in  1  clock
nRST  in  1  reset, synchronous, active-low
miss_valid  in  1  ITLB miss present
miss_VPN  in  20  missing VPN
miss_ASID  in  16  ASID of the miss
miss_ready  out  1  miss accepted this cycle (combinational)
req_valid  out  1  request to L2 TLB
req_tag  out  2  tag of the request
req_VPN  out  20  VPN of the request
req_ASID  out  16  ASID of the request
req_ready  in  1  L2 TLB accepts the request
resp_valid  in  1  L2 TLB response
resp_tag  in  2  tag of the response
resp_pte  in  32  Sv32 PTE (pte_t)
resp_is_4MB  in  1  leaf found at level 1
resp_page_fault  in  1  walk faulted
fill_valid  out  1  registered fill to the ITLB
fill_VPN  out  20  VPN of the fill
fill_ASID  out  16  ASID of the fill
fill_pte  out  32  PTE of the fill
fill_is_4MB  out  1  selects 4MB array vs 4KB array
fill_page_fault  out  1  fault indication for fetch
flush  in  1  sfence/ASID change; squash all entries

Behaviour:
- Each tag entry is a small state machine: FREE -> PENDING (allocated, not sent) -> SENT (req handshake done) -> FREE on response.
- FLUSH: PENDING -> FREE immediately. SENT -> SQUASHED. SQUASHED -> FREE on its response, which produces no fill.
- Reset: all entries FREE; outputs miss_ready=0, req_valid=0, fill_valid=0, all data outputs 0.
- Merge check: a miss hits an entry in PENDING or SENT whose VPN and ASID match.
  - Merge excludes SQUASHED entries and any entry receiving a response this cycle.
  - On a merge, miss_ready=1 and no allocation is made. Merges are allowed when all tags are busy.
- Allocation on no merge: lowest-index FREE entry; miss_ready=1. No FREE entry -> miss_ready=0 and the miss stalls.
- A tag freed by a response or flush this cycle is not allocatable until the next cycle.
- Issue: req_valid=1 when any entry is PENDING. Select the lowest-index PENDING entry.
  - req_tag, req_VPN and req_ASID must hold stable while req_valid && !req_ready.
  - Handshake (req_valid && req_ready) moves the entry to SENT in the next cycle.
  - A newly allocated entry is issuable the cycle after allocation (no bypass).
- Response:
  - resp_valid with resp_tag naming a SENT entry: entry -> FREE. Next cycle fill_valid=1 carrying the entry's VPN/ASID and resp_pte/resp_is_4MB/resp_page_fault.
  - fill_valid lasts exactly 1 cycle per response. Latency is resp to fill = 1 cycle.
  - Response to a SQUASHED entry: entry -> FREE, fill_valid=0.
  - Response to a FREE or PENDING tag is a protocol error: ignored, no state change (an assertion fires in simulation).
- Flush priority:
  - flush in the same cycle as a miss: miss_ready=0.
  - flush in the same cycle as a response to a SENT entry: the fill is suppressed.
  - flush in the same cycle as a req handshake: the entry becomes SQUASHED, not FREE, since the L2 TLB will respond.
  - flush does not cancel a fill already registered.
- Simultaneous allocate, issue and response on different tags in one cycle are all legal.
- Reset asserted mid-operation: all entries FREE and outstanding responses are abandoned. The L2 TLB is reset in the same cycle.

Decomposition:
- system_types: ITLB_L2_TLB_REQ_TAG_COUNT/WIDTH, VPN_WIDTH, ASID_WIDTH and pte_t already exist there.
- Add to system_types: typedef enum itlb_req_state_t {FREE, PENDING, SENT, SQUASHED} and struct itlb_req_entry_t {state, VPN, ASID}.
- Sub-module: lowest-index priority encoder pe_lsb, instanced twice (free-entry select, pending-entry select). Everything else is flat.

Test Plan:
- Miss VPN=0x12345/ASID=0x0001 with req_ready=1 -> miss_ready=1 same cycle; req_valid/req_tag=0 next cycle; resp tag 0, pte=0x0ABCD0CF -> fill_valid 1 cycle later with VPN=0x12345, is_4MB=0.
- Misses VPN 0x1..0x4 (distinct), then a 5th VPN=0x5 -> 5th stalls (miss_ready=0) until resp_tag=2 returns; it then gets tag 2 one cycle after the response.
- Full table, miss VPN=0x3 with a matching ASID -> miss_ready=1 (merge), no new req; a single fill on the tag 2 response.
- Tags 0,1 SENT, tag 2 PENDING, then flush -> tag 2 never issued; responses for tags 0,1 produce no fill; all 4 tags allocatable after.
- req_ready=0 for 3 cycles with tags 0,1 pending -> req_tag=0 and VPN held stable; handshake order tag 0 then tag 1.
- resp_page_fault=1 with resp_is_4MB=1 on tag 1 -> fill_page_fault=1, fill_is_4MB=1; tag 1 reusable the following cycle.
